// File: rtl/secded_encoder_engine.sv
// SECDED (16,11) encoder engine.
// Reads NUM_MSG 11-bit messages from byte memory, builds extended Hamming
// codewords and writes them back as two bytes each.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for i_req after reset
// S_RD_LO  | present address of source low byte
// S_RD_HI  | capture low byte, present address of source high byte
// S_CALC   | capture d[11:9], register codeword
// S_WR_LO  | write codeword low byte
// S_WR_HI  | write codeword high byte, advance or finish
// S_DONE   | run complete, o_done asserted, i_req restarts
module secded_encoder_engine #(
  parameter int NUM_MSG  = 15,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 30
) (
  input  logic       i_clk,
  input  logic       i_reset,      // active low, asynchronous
  input  logic       i_req,
  output logic       o_done,
  output logic [7:0] o_mem_addr,
  output logic       o_mem_wr_en,
  output logic [7:0] o_mem_wdata,
  input  logic [7:0] i_mem_rdata
);

  localparam int              CNT_W = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(NUM_MSG - 1);
  localparam logic [7:0]      SRC_B = 8'(SRC_BASE);
  localparam logic [7:0]      DST_B = 8'(DST_BASE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_LO = 3'd1,
    S_RD_HI = 3'd2,
    S_CALC  = 3'd3,
    S_WR_LO = 3'd4,
    S_WR_HI = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_lo;
  logic [15:0]      r_cw;
  logic             r_done;

  logic [11:1]      w_d;
  logic             w_p8, w_p4, w_p2, w_p1, w_p0;
  logic [15:0]      w_cw;
  logic [7:0]       w_off;
  logic             w_unused;

  // Source high byte bits [7:3] carry no message data.
  assign w_unused = ^i_mem_rdata[7:3];

  // Message word and codeword built from the captured low byte and live high byte.
  always_comb begin
    w_d  = {i_mem_rdata[2:0], r_lo};
    w_p8 = ^w_d[11:5];
    w_p4 = (^w_d[11:8]) ^ (^w_d[4:2]);
    w_p2 = w_d[11] ^ w_d[10] ^ w_d[7] ^ w_d[6] ^ w_d[4] ^ w_d[3] ^ w_d[1];
    w_p1 = w_d[11] ^ w_d[9] ^ w_d[7] ^ w_d[5] ^ w_d[4] ^ w_d[2] ^ w_d[1];
    w_p0 = (^w_d) ^ w_p8 ^ w_p4 ^ w_p2 ^ w_p1;
    w_cw = {w_d[11:5], w_p8, w_d[4:2], w_p4, w_d[1], w_p2, w_p1, w_p0};
    w_off = 8'({r_cnt, 1'b0});
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Message counter, captured data, codeword and registered done flag.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt  <= '0;
      r_lo   <= '0;
      r_cw   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE);
      case (r_state)
        S_IDLE, S_DONE: if (i_req) r_cnt <= '0;
        S_RD_HI:        r_lo <= i_mem_rdata;
        S_CALC:         r_cw <= w_cw;
        S_WR_HI:        if (r_cnt != LAST) r_cnt <= r_cnt + 1'b1;
        default:        ;
      endcase
    end
  end

  // Next-state logic; i_req is only looked at in IDLE and DONE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_req) w_next = S_RD_LO;
      S_RD_LO: w_next = S_RD_HI;
      S_RD_HI: w_next = S_CALC;
      S_CALC:  w_next = S_WR_LO;
      S_WR_LO: w_next = S_WR_HI;
      S_WR_HI: w_next = (r_cnt == LAST) ? S_DONE : S_RD_LO;
      S_DONE:  if (i_req) w_next = S_RD_LO;
      default: w_next = S_IDLE;
    endcase
  end

  // Memory interface outputs decoded from state; all zero outside access states.
  always_comb begin
    o_mem_addr  = 8'd0;
    o_mem_wr_en = 1'b0;
    o_mem_wdata = 8'd0;
    case (r_state)
      S_RD_LO: o_mem_addr = SRC_B + w_off;
      S_RD_HI: o_mem_addr = SRC_B + w_off + 8'd1;
      S_WR_LO: begin
        o_mem_addr  = DST_B + w_off;
        o_mem_wr_en = 1'b1;
        o_mem_wdata = r_cw[7:0];
      end
      S_WR_HI: begin
        o_mem_addr  = DST_B + w_off + 8'd1;
        o_mem_wr_en = 1'b1;
        o_mem_wdata = r_cw[15:8];
      end
      default: ;
    endcase
  end

  assign o_done = r_done;

endmodule

// File: tb/tb_secded_encoder_engine.sv
module tb_secded_encoder_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req, req1;
  logic       done, done1;
  logic [7:0] addr, addr1, wdata, wdata1, rdata, rdata1;
  logic       wr_en, wr_en1;

  int errors = 0;
  int checks = 0;

  logic [7:0]  mem  [256];
  logic [7:0]  mem1 [256];
  int          wr_hits [256];
  int          wr_oob;
  logic [10:0] exp_d [15];

  always #5 clk = ~clk;

  secded_encoder_engine u_dut (
    .i_clk(clk), .i_reset(rst_n), .i_req(req), .o_done(done),
    .o_mem_addr(addr), .o_mem_wr_en(wr_en), .o_mem_wdata(wdata), .i_mem_rdata(rdata)
  );

  secded_encoder_engine #(.NUM_MSG(1)) u_dut1 (
    .i_clk(clk), .i_reset(rst_n), .i_req(req1), .o_done(done1),
    .o_mem_addr(addr1), .o_mem_wr_en(wr_en1), .o_mem_wdata(wdata1), .i_mem_rdata(rdata1)
  );

  // Registered-read byte memories.
  always @(posedge clk) begin
    rdata <= mem[addr];
    if (wr_en) begin
      mem[addr] = wdata;
      wr_hits[addr] = wr_hits[addr] + 1;
      if (addr < 8'd30 || addr > 8'd59) wr_oob = wr_oob + 1;
    end
  end

  always @(posedge clk) begin
    rdata1 <= mem1[addr1];
    if (wr_en1) mem1[addr1] = wdata1;
  end

  // Extended Hamming: data fills non-power-of-two positions 3,5,6,7,9..15 in
  // order, parity at position 2^k covers positions with bit k set, bit 0 is
  // overall parity.
  function automatic logic [15:0] ref_cw(input logic [10:0] d);
    logic [15:0] c = '0;
    int k = 0;
    for (int pos = 1; pos < 16; pos++)
      if ((pos & (pos - 1)) != 0) begin
        c[pos] = d[k];
        k++;
      end
    for (int p = 1; p < 16; p = p * 2) begin
      logic par = 1'b0;
      for (int pos = 1; pos < 16; pos++)
        if ((pos & p) != 0 && pos != p) par ^= c[pos];
      c[p] = par;
    end
    c[0] = ^c[15:1];
    return c;
  endfunction

  function automatic int syndrome(input logic [15:0] c);
    int s = 0;
    for (int pos = 1; pos < 16; pos++)
      if (c[pos]) s = s ^ pos;
    return s;
  endfunction

  task automatic load_msg(input int i, input logic [10:0] d, input logic [4:0] junk);
    mem[2*i]     = d[7:0];
    mem[2*i + 1] = {junk, d[10:8]};
    exp_d[i]     = d;
  endtask

  task automatic load_random;
    for (int i = 0; i < 15; i++)
      load_msg(i, 11'($urandom), 5'($urandom));
  endtask

  task automatic clear_dest;
    for (int a = 30; a < 60; a++) mem[a] = 8'hA5;
    for (int a = 0; a < 256; a++) wr_hits[a] = 0;
    wr_oob = 0;
  endtask

  // Raise req for one sampling edge, then count cycles until done is seen.
  task automatic run_main(input bit toggle, output int cyc, output logic first_done);
    @(negedge clk);
    req = 1'b1;
    @(posedge clk);
    cyc = 0;
    first_done = 1'bx;
    while (cyc < 300) begin
      @(negedge clk);
      if (toggle && cyc < 70) req = ~req;
      else                    req = 1'b0;
      if (cyc == 1) first_done = done;
      if (cyc > 0 && done) break;
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req   = 1'b0;
    req1  = 1'b0;
    for (int a = 0; a < 256; a++) begin
      mem[a]  = 8'h00;
      mem1[a] = 8'h00;
    end
    clear_dest;
    #1;
    checks++;
    if ({done, wr_en, addr, wdata} !== 18'd0) begin
      errors++;
      $display("FAIL reset_async: done=%b wr_en=%b addr=%h wdata=%h, want all 0", done, wr_en, addr, wdata);
    end
    repeat (3) @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    checks++;
    if ({done, wr_en, addr, wdata} !== 18'd0) begin
      errors++;
      $display("FAIL reset_hold: done=%b wr_en=%b addr=%h wdata=%h, want all 0", done, wr_en, addr, wdata);
    end
    req = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (done !== 1'b0 || wr_en !== 1'b0 || addr !== 8'd0) begin
      errors++;
      $display("FAIL idle_wait: done=%b wr_en=%b addr=%h, want 0 0 00", done, wr_en, addr);
    end
  endtask

  task automatic test_directed;
    int cyc;
    logic fd;
    load_random;
    load_msg(0, 11'h001, 5'b00000);
    load_msg(1, 11'h7FF, 5'b10101);
    load_msg(2, 11'h400, 5'b11111);
    load_msg(3, 11'h000, 5'b01010);
    clear_dest;
    run_main(1'b0, cyc, fd);
    checks++;
    if (cyc !== 76) begin
      errors++;
      $display("FAIL directed_latency: got %0d cycles, want 76", cyc);
    end
    checks++;
    if ({mem[31], mem[30]} !== 16'h000F || {mem[33], mem[32]} !== 16'hFFFF ||
        {mem[35], mem[34]} !== 16'h8117 || {mem[37], mem[36]} !== 16'h0000) begin
      errors++;
      $display("FAIL directed_cw: got %h %h %h %h, want 000f ffff 8117 0000",
               {mem[31], mem[30]}, {mem[33], mem[32]}, {mem[35], mem[34]}, {mem[37], mem[36]});
    end
    for (int i = 0; i < 15; i++) begin
      checks++;
      if ({mem[31 + 2*i], mem[30 + 2*i]} !== ref_cw(exp_d[i])) begin
        errors++;
        $display("FAIL directed_msg%0d: got %h, want %h", i, {mem[31 + 2*i], mem[30 + 2*i]}, ref_cw(exp_d[i]));
      end
    end
    checks++;
    if (wr_oob !== 0) begin
      errors++;
      $display("FAIL directed_oob: %0d writes outside 30..59, want 0", wr_oob);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (done !== 1'b1 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL done_hold: done=%b wr_en=%b, want 1 0", done, wr_en);
    end
  endtask

  task automatic test_single;
    int cyc = 0;
    mem1[0] = 8'h01;
    mem1[1] = 8'h00;
    @(negedge clk);
    req1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req1 = 1'b0;
    while (!done1 && cyc < 50) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (cyc !== 6) begin
      errors++;
      $display("FAIL single_latency: got %0d cycles, want 6", cyc);
    end
    checks++;
    if (mem1[30] !== 8'h0F || mem1[31] !== 8'h00) begin
      errors++;
      $display("FAIL single_bytes: got %h %h, want 0f 00", mem1[30], mem1[31]);
    end
  endtask

  task automatic test_random_restart;
    int cyc;
    logic fd;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL restart_pre_done: done=%b, want 1", done);
    end
    load_random;
    clear_dest;
    run_main(1'b0, cyc, fd);
    checks++;
    if (fd !== 1'b0) begin
      errors++;
      $display("FAIL restart_done_drop: done=%b one cycle after restart, want 0", fd);
    end
    checks++;
    if (cyc !== 76) begin
      errors++;
      $display("FAIL restart_latency: got %0d cycles, want 76", cyc);
    end
    for (int i = 0; i < 15; i++) begin
      logic [15:0] c = {mem[31 + 2*i], mem[30 + 2*i]};
      checks++;
      if (c !== ref_cw(exp_d[i]) || syndrome(c) != 0 || (^c) !== 1'b0 ||
          wr_hits[30 + 2*i] != 1 || wr_hits[31 + 2*i] != 1) begin
        errors++;
        $display("FAIL random_msg%0d: got %h syn=%0d par=%b hits=%0d/%0d, want %h syn=0 par=0 hits=1/1",
                 i, c, syndrome(c), ^c, wr_hits[30 + 2*i], wr_hits[31 + 2*i], ref_cw(exp_d[i]));
      end
    end
    checks++;
    if (wr_oob !== 0) begin
      errors++;
      $display("FAIL random_oob: %0d writes outside 30..59, want 0", wr_oob);
    end
  endtask

  task automatic test_req_toggle;
    int cyc;
    logic fd;
    int bad = 0;
    load_random;
    clear_dest;
    run_main(1'b1, cyc, fd);
    checks++;
    if (cyc !== 76) begin
      errors++;
      $display("FAIL toggle_latency: got %0d cycles, want 76 (run 75)", cyc);
    end
    for (int i = 0; i < 15; i++)
      if ({mem[31 + 2*i], mem[30 + 2*i]} !== ref_cw(exp_d[i])) bad++;
    checks++;
    if (bad != 0 || wr_oob != 0) begin
      errors++;
      $display("FAIL toggle_data: %0d wrong codewords, %0d stray writes, want 0 0", bad, wr_oob);
    end
  endtask

  task automatic test_reset_midrun;
    int cyc = 0;
    int bad = 0;
    logic fd;
    load_random;
    clear_dest;
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    while (!(wr_en && addr == 8'd45) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc >= 200) begin
      errors++;
      $display("FAIL midrun_reach: WR_HI of message 7 not seen within 200 cycles");
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({done, wr_en, addr, wdata} !== 18'd0) begin
      errors++;
      $display("FAIL midrun_async: done=%b wr_en=%b addr=%h wdata=%h, want all 0", done, wr_en, addr, wdata);
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 7; i++)
      if ({mem[31 + 2*i], mem[30 + 2*i]} !== ref_cw(exp_d[i])) bad++;
    checks++;
    if (bad != 0 || mem[44] !== ref_cw(exp_d[7])[7:0]) begin
      errors++;
      $display("FAIL midrun_kept: %0d bad early codewords, byte44=%h, want 0 and %h", bad, mem[44], ref_cw(exp_d[7]) & 16'h00FF);
    end
    bad = 0;
    for (int a = 45; a < 60; a++) if (mem[a] !== 8'hA5) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midrun_unwritten: %0d bytes in 45..59 changed, byte45=%h, want 0 and a5", bad, mem[45]);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    clear_dest;
    run_main(1'b0, cyc, fd);
    bad = 0;
    for (int i = 0; i < 15; i++)
      if ({mem[31 + 2*i], mem[30 + 2*i]} !== ref_cw(exp_d[i])) bad++;
    checks++;
    if (cyc !== 76 || bad != 0 || wr_oob != 0) begin
      errors++;
      $display("FAIL midrun_rerun: latency %0d, %0d bad codewords, %0d stray, want 76 0 0", cyc, bad, wr_oob);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_single;
    test_random_restart;
    test_req_toggle;
    test_reset_midrun;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/secded_encoder_engine.md
SECDED_ENCODER_ENGINE -- requirements
Module: secded_encoder_engine

Interface
REQ-001 Parameter NUM_MSG, default 15: number of messages encoded per run.
REQ-002 Parameter SRC_BASE, default 0: byte address of the first source message.
REQ-003 Parameter DST_BASE, default 30: byte address of the first destination codeword.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; low forces the reset state immediately.
REQ-006 req  input  1  start request, level-sampled in IDLE and DONE states.
REQ-007 done  output  1  high while in DONE state.
REQ-008 mem_addr  output  8  byte address to data memory.
REQ-009 mem_wr_en  output  1  write strobe, one byte per cycle.
REQ-010 mem_wdata  output  8  write data.
REQ-011 mem_rdata  input  8  read data, valid the cycle after mem_addr is presented (registered read).

Function
REQ-012 Message i (0..NUM_MSG-1) memory layout:
- Source low byte at SRC_BASE+2i holds d[8:1].
- Source high byte at SRC_BASE+2i+1, bits [2:0], hold d[11:9]; bits [7:3] are ignored.
REQ-013 Parity equations:
- p8 = XOR d[11:5].
- p4 = XOR d[11:8] ^ XOR d[4:2].
- p2 = d11^d10^d7^d6^d4^d3^d1.
- p1 = d11^d9^d7^d5^d4^d2^d1.
- p0 = XOR of all d bits ^ p8^p4^p2^p1.
REQ-014 Codeword cw[15:0] = {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0}.
REQ-015 cw[7:0] is written to DST_BASE+2i and cw[15:8] to DST_BASE+2i+1.
REQ-016 FSM states: IDLE, RD_LO, RD_HI, CALC, WR_LO, WR_HI, DONE.
REQ-017 IDLE with req=1 goes to RD_LO with message counter = 0; IDLE with req=0 stays in IDLE.
REQ-018 RD_LO: mem_addr = SRC_BASE+2i; next state RD_HI.
REQ-019 RD_HI: capture mem_rdata as the low byte; mem_addr = SRC_BASE+2i+1; next state CALC.
REQ-020 CALC: capture mem_rdata[2:0] as d[11:9]; register the codeword; next state WR_LO.
REQ-021 WR_LO: mem_wr_en=1, mem_addr = DST_BASE+2i, mem_wdata = cw[7:0]; next state WR_HI.
REQ-022 WR_HI: mem_wr_en=1, mem_addr = DST_BASE+2i+1, mem_wdata = cw[15:8].
- If i = NUM_MSG-1, next state is DONE.
- Otherwise i increments and next state is RD_LO.
REQ-023 Timing:
- Each message takes exactly 5 cycles.
- done rises 5*NUM_MSG+1 cycles after the edge on which req is sampled in IDLE (76 cycles for the default).
REQ-024 DONE holds done=1 while req=0; DONE with req=1 starts a new run (goes to RD_LO, counter = 0, done drops next cycle).
REQ-025 req changes while in RD_LO..WR_HI are ignored.
REQ-026 mem_wr_en is 0 in every state except WR_LO and WR_HI.
REQ-027 Message counter width is ceil(log2(NUM_MSG)), minimum 1 bit; it never wraps within a run.
REQ-028 Address arithmetic is modulo 256.

Reset
REQ-029 While reset=0, the block SHALL hold:
- state = IDLE, done = 0, mem_wr_en = 0;
- mem_addr = 0, mem_wdata = 0;
- counter and data registers = 0.
REQ-030 Reset asserted mid-run aborts the run immediately with no further writes; bytes already written stay in memory.
REQ-031 After reset deasserts, the block waits in IDLE for req.

Verification
REQ-032 d = 11'h001 at source 0/1, NUM_MSG = 1 -> bytes 30 = 8'h0F and 31 = 8'h00; done rises 6 cycles after req is sampled.
REQ-033 d = 11'h7FF, with garbage 5'b10101 in source high byte bits [7:3] -> codeword 16'hFFFF (bytes 8'hFF, 8'hFF).
REQ-034 d = 11'h400 -> codeword 16'h8117; d = 11'h000 -> codeword 16'h0000.
REQ-035 15 random messages, default parameters:
- Every destination pair matches the REQ-013/014 reference model.
- A decoded copy of every codeword shows syndrome 0 and overall parity 0.
- No write goes outside bytes 30..59.
- done is held until req is raised again.
REQ-036 Reset pulled low during WR_HI of message 7 -> outputs go to 0 asynchronously; bytes for messages 0..6 and byte 44 are intact; byte 45 is unwritten; a new req re-encodes all 15 messages correctly.
REQ-037 req toggled every cycle during a run -> no effect on sequencing; run length is 75 cycles.
